player_ctrl: RTL and testbench
==============================

Name: player_ctrl

Overview:
- Parametrised successor to the single-player hit/life tracker in the tennis game.
- Edge-detects the player button and opens a bounded hit window whenever the ball becomes hittable.
- Classifies each swing as hit, early swing or miss; keeps a configurable life count and a saturating rally score.
- Sits between the ball-position logic (drives hittable_ball and start_game) and the court/scoreboard display logic (consumes return_hit, lives, game_over, rally).

Parameters:
- MAX_LIVES, 3: lives loaded on game start. Range 1..2^LIFE_W-1.
- LIFE_W, 2: width of the lives output.
- HIT_WINDOW, 8: maximum cycles the swing window stays open after hittable_ball rises. 0 means the window is bounded only by hittable_ball.
- WIN_W, 8: width of the window counter. Must satisfy HIT_WINDOW < 2^WIN_W.
- SCORE_W, 8: width of the rally counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- button  in  1  player button, already synchronised; level
- hittable_ball  in  1  ball is inside this player's hit zone; level
- start_game  in  1  game enable; level. Low aborts to IDLE.
- return_hit  out  1  one-cycle pulse on a successful hit
- miss  out  1  one-cycle pulse on each life lost
- lives  out  LIFE_W  remaining lives
- game_over  out  1  level, high while in OVER
- rally  out  SCORE_W  consecutive hits since the last life lost; saturates at all-ones

Behaviour:
- Decided interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: return_hit=0, miss=0, lives=MAX_LIVES, game_over=0, rally=0, state=IDLE, window counter=0, button history=0.
- Press definition: press = button & ~button_q (registered rising edge). A held button counts once only.
- All outputs are registered. Pulses appear one cycle after the cycle in which the causing input condition is sampled.
- IDLE:
  - lives=MAX_LIVES, rally=0.
  - start_game=1 -> WAIT.
- WAIT (ball not yet hittable):
  - press & hittable_ball -> hit: return_hit pulse, rally+1, go COOL. A hit takes priority even in the cycle hittable_ball rises.
  - hittable_ball rising (no press) -> WINDOW; load counter = HIT_WINDOW.
  - press & ~hittable_ball -> early swing: life loss.
- WINDOW:
  - press & hittable_ball -> hit, go COOL.
  - hittable_ball falls, or counter reaches 1 with HIT_WINDOW != 0 -> life loss.
  - Press in the same cycle as counter expiry counts as a hit.
  - Counter decrements each cycle; it never decrements when HIT_WINDOW=0.
- COOL: wait for hittable_ball=0, then -> WAIT. Presses in COOL are ignored (no double hit, no penalty).
- Life loss: miss pulse, rally cleared to 0.
  - If lives > 1: lives decrements, go COOL (ball must leave the zone before re-arming).
  - If lives == 1: lives -> 0, go OVER, game_over=1.
- OVER: presses are ignored. start_game=0 -> IDLE, which restores lives on the next start.
- start_game=0 in WAIT/WINDOW/COOL -> IDLE next cycle; no miss pulse; lives and rally restored.
- Rally counter: rally at all-ones stays all-ones on a further hit. return_hit still pulses.
- Width rules: lives never underflows. rally never wraps.
- rst mid-rally or mid-window: immediately returns to reset values, with no pulse emitted.

Decomposition:
- Shared package tennis_pkg:
  - state encoding: IDLE, WAIT, WINDOW, COOL, OVER (3-bit)
  - default parameter constants shared with the ball/court blocks
- One sub-module, edge_rise: registered rising-edge detector with async reset. Also reusable for the serve button.

Test Plan:
- Start, hittable_ball high 3 cycles, press at cycle 2 -> one return_hit pulse; rally=1; lives=3; no miss.
- HIT_WINDOW=4, hittable_ball held 10 cycles, no press -> miss pulse 4 cycles after entering WINDOW; lives=2; rally=0.
- Three early presses in WAIT, each followed by a hittable_ball pulse to clear COOL -> lives 3->2->1->0; game_over=1 after the third; later presses ignored; start_game low -> lives=3.
- Press held across hittable_ball rise and through the window -> counted once at its edge only (early swing if the edge occurred before the rise); no further hit.
- SCORE_W=2, five consecutive hits -> rally 1,2,3,3,3; five return_hit pulses.
- rst asserted mid-WINDOW with rally=2 -> outputs immediately at reset values with no pulse; start_game then re-arms from IDLE.

Source files
------------

// File: rtl/tennis_pkg.sv
// Shared tennis game types and default constants.
// Used by player, ball and court blocks.
package tennis_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    WINDOW,
    COOL,
    OVER
  } state_t;

  localparam int DEF_MAX_LIVES  = 3;
  localparam int DEF_LIFE_W     = 2;
  localparam int DEF_HIT_WINDOW = 8;
  localparam int DEF_WIN_W      = 8;
  localparam int DEF_SCORE_W    = 8;

endpackage

// File: rtl/player_ctrl_if.sv
// Player control bundle between ball logic and display.
// master drives the game inputs, slave is the player block.
interface player_ctrl_if
  import tennis_pkg::*;
#(
  parameter int LIFE_W  = DEF_LIFE_W,
  parameter int SCORE_W = DEF_SCORE_W
);

  logic               button;
  logic               hittable_ball;
  logic               start_game;
  logic               return_hit;
  logic               miss;
  logic [LIFE_W-1:0]  lives;
  logic               game_over;
  logic [SCORE_W-1:0] rally;

  modport master (
    output button, hittable_ball, start_game,
    input  return_hit, miss, lives,
    input  game_over, rally
  );

  modport slave (
    input  button, hittable_ball, start_game,
    output return_hit, miss, lives,
    output game_over, rally
  );

endinterface

// File: rtl/edge_rise.sv
// Registered rising-edge detector with async reset.
// rise is high while d is high and was low last cycle.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/player_ctrl.sv
// Single-player swing tracker: hit window, lives, rally.
// All outputs are registered from the next-state logic.
module player_ctrl
  import tennis_pkg::*;
#(
  parameter int MAX_LIVES  = DEF_MAX_LIVES,
  parameter int LIFE_W     = DEF_LIFE_W,
  parameter int HIT_WINDOW = DEF_HIT_WINDOW,
  parameter int WIN_W      = DEF_WIN_W,
  parameter int SCORE_W    = DEF_SCORE_W
) (
  input logic          clk,
  input logic          rst,
  player_ctrl_if.slave bus
);

  localparam logic [LIFE_W-1:0] LIVES0 =
    LIFE_W'(MAX_LIVES);
  localparam logic [WIN_W-1:0] WIN0 =
    WIN_W'(HIT_WINDOW);
  localparam bit TIMED = (HIT_WINDOW != 0);

  state_t             state, state_n;
  logic [WIN_W-1:0]   cnt, cnt_n;
  logic [LIFE_W-1:0]  lives_q, lives_n;
  logic [SCORE_W-1:0] rally_q, rally_n;
  logic               hit_q, hit_n;
  logic               miss_q, miss_n;
  logic               over_q;
  logic               press;
  logic               lose;
  logic               hb;

  edge_rise u_btn (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.button),
    .rise (press)
  );

  assign hb = bus.hittable_ball;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lives_n = lives_q;
    rally_n = rally_q;
    hit_n   = 1'b0;
    miss_n  = 1'b0;
    lose    = 1'b0;
    if (!bus.start_game) begin
      state_n = IDLE;
      cnt_n   = '0;
      lives_n = LIVES0;
      rally_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          lives_n = LIVES0;
          rally_n = '0;
          state_n = WAIT;
        end
        WAIT: begin
          if (press && hb) hit_n = 1'b1;
          else if (press)  lose  = 1'b1;
          else if (hb) begin
            state_n = WINDOW;
            cnt_n   = WIN0;
          end
        end
        WINDOW: begin
          if (press && hb) hit_n = 1'b1;
          else if (!hb) lose = 1'b1;
          else if (TIMED && cnt == WIN_W'(1))
            lose = 1'b1;
          else if (TIMED)
            cnt_n = cnt - WIN_W'(1);
        end
        COOL: begin
          if (!hb) state_n = WAIT;
        end
        OVER: ;
        default: state_n = IDLE;
      endcase
      if (hit_n) begin
        state_n = COOL;
        cnt_n   = '0;
        if (rally_q != '1)
          rally_n = rally_q + SCORE_W'(1);
      end
      // The last life parks in OVER; otherwise the ball must leave first.
      if (lose) begin
        miss_n  = 1'b1;
        rally_n = '0;
        cnt_n   = '0;
        if (lives_q > LIFE_W'(1)) begin
          lives_n = lives_q - LIFE_W'(1);
          state_n = COOL;
        end else begin
          lives_n = '0;
          state_n = OVER;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      lives_q <= LIVES0;
      rally_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      lives_q <= lives_n;
      rally_q <= rally_n;
      hit_q   <= hit_n;
      miss_q  <= miss_n;
      over_q  <= (state_n == OVER);
    end
  end

  assign bus.return_hit = hit_q;
  assign bus.miss       = miss_q;
  assign bus.lives      = lives_q;
  assign bus.game_over  = over_q;
  assign bus.rally      = rally_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed game scenarios plus
// random play, checked against a behavioural game model.
module tb_player_ctrl;
  import tennis_pkg::*;

  localparam int MAXL = 3;
  localparam int LW   = 2;
  localparam int HW   = 4;
  localparam int WW   = 8;
  localparam int SW   = 2;
  localparam int RMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  player_ctrl_if #(.LIFE_W(LW), .SCORE_W(SW)) bus ();

  player_ctrl #(
    .MAX_LIVES  (MAXL),
    .LIFE_W     (LW),
    .HIT_WINDOW (HW),
    .WIN_W      (WW),
    .SCORE_W    (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Game model: playing / over / ball-leaving flags,
  // window cycles left, lives and rally as integers.
  int m_on, m_over, m_cool, m_win;
  int m_lives, m_rally, m_bprev;
  int e_hit, e_miss;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d",
               tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_over = 0; m_cool = 0; m_win = 0;
    m_lives = MAXL; m_rally = 0; m_bprev = 0;
    e_hit = 0; e_miss = 0;
  endtask

  task automatic lose_life();
    e_miss  = 1;
    m_rally = 0;
    m_win   = 0;
    if (m_lives > 1) begin
      m_lives--;
      m_cool = 1;
    end else begin
      m_lives = 0;
      m_over  = 1;
    end
  endtask

  task automatic model(input logic b,
                       input logic h,
                       input logic s);
    int press;
    press   = (b && m_bprev == 0) ? 1 : 0;
    m_bprev = b ? 1 : 0;
    e_hit   = 0;
    e_miss  = 0;
    if (!s) begin
      m_on = 0; m_over = 0; m_cool = 0; m_win = 0;
      m_lives = MAXL; m_rally = 0;
    end else if (m_on == 0) begin
      m_on = 1;
    end else if (m_over != 0) begin
    end else if (m_cool != 0) begin
      if (!h) m_cool = 0;
    end else if (press != 0 && h) begin
      e_hit   = 1;
      m_rally = (m_rally == RMAX) ? RMAX : m_rally + 1;
      m_cool  = 1;
      m_win   = 0;
    end else if (m_win > 0) begin
      if (!h || m_win == 1) lose_life();
      else m_win--;
    end else if (press != 0) begin
      lose_life();
    end else if (h) begin
      m_win = HW;
    end
  endtask

  task automatic check_all();
    chk("return_hit", 32'(bus.return_hit), e_hit);
    chk("miss",       32'(bus.miss),       e_miss);
    chk("lives",      32'(bus.lives),      m_lives);
    chk("game_over",  32'(bus.game_over),  m_over);
    chk("rally",      32'(bus.rally),      m_rally);
  endtask

  task automatic step(input logic b,
                      input logic h,
                      input logic s);
    @(negedge clk);
    bus.button        = b;
    bus.hittable_ball = h;
    bus.start_game    = s;
    @(posedge clk);
    model(b, h, s);
    #1;
    check_all();
  endtask

  // Async reset in the middle of a cycle, then release.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    bus.button        = 1'b0;
    bus.hittable_ball = 1'b0;
    bus.start_game    = 1'b0;
    @(posedge clk);
    model(1'b0, 1'b0, 1'b0);
    #1;
    check_all();
  endtask

  logic rb, rh, rs;

  initial begin
    bus.button        = 1'b0;
    bus.hittable_ball = 1'b0;
    bus.start_game    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_lives", 32'(bus.lives), 3);
    @(negedge clk);
    rst = 1'b0;

    // One clean hit inside the window
    step(0, 0, 1);
    step(0, 1, 1);
    step(1, 1, 1);
    chk("p1_hit", 32'(bus.return_hit), 1);
    chk("p1_rally", 32'(bus.rally), 1);
    step(0, 1, 1);
    step(0, 0, 1);

    // Window expiry
    step(0, 1, 1);
    repeat (3) step(0, 1, 1);
    chk("p2_nomiss", 32'(bus.miss), 0);
    step(0, 1, 1);
    chk("p2_miss", 32'(bus.miss), 1);
    chk("p2_lives", 32'(bus.lives), 2);
    step(0, 0, 1);

    // Early swings to game over
    step(0, 0, 0);
    step(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1);
      chk("p3_lives", 32'(bus.lives), 2 - i);
      step(0, 1, 1);
      step(0, 0, 1);
    end
    chk("p3_over", 32'(bus.game_over), 1);
    step(1, 1, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("p3_restore", 32'(bus.lives), 3);

    // Held button across the ball rise
    step(0, 0, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 1);
    step(0, 0, 1);

    // Rally saturation
    step(0, 0, 0);
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1);
      step(1, 1, 1);
      chk("p5_rally", 32'(bus.rally),
          (i + 1 > RMAX) ? RMAX : i + 1);
      step(0, 0, 1);
    end

    // Reset in the middle of a window with rally 2
    step(0, 0, 0);
    step(0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 1);
      step(0, 0, 1);
    end
    step(0, 1, 1);
    step(0, 1, 1);
    do_reset();
    chk("p6_rally", 32'(bus.rally), 0);
    step(0, 0, 1);
    step(0, 1, 1);
    step(1, 1, 1);
    chk("p6_rearm", 32'(bus.return_hit), 1);

    // Random play
    rb = 0; rh = 0; rs = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) do_reset();
      if (rs) rs = ($urandom_range(59) != 0);
      else    rs = ($urandom_range(2) == 0);
      if ($urandom_range(4) == 0) rh = ~rh;
      if ($urandom_range(2) == 0) rb = ~rb;
      step(rb, rh, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
